// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IF_STATE_RUN   = 2'd0,  // issuing fetches
        IF_STATE_DRAIN = 2'd1,  // waiting for stale responses, no issue
        IF_STATE_HALT  = 2'd2   // fetch fault seen, no issue until redirect
    } if_state_e;

    // One instruction buffer entry handed to decode (65 bits).
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            fault;
    } ibuf_entry_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Bundle of redirect, imem request/response and decode handshake signals.
// Latency: n/a (wires only).
// Backpressure: imem request and decode channels are valid/ready; imem response has none.
// master = fetch unit side, slave = memory/decode/redirect side.
interface if_fetch_unit_if;
    import if_pkg::*;

    logic            pcsrc;
    logic [XLEN-1:0] jaddr;
    logic            exception;
    logic [XLEN-1:0] eaddr;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;

    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            imem_rsp_err;

    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;
    logic            id_fault;

    modport master (
        input  pcsrc, jaddr, exception, eaddr,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output id_valid, id_instr, id_pc, id_fault,
        input  id_ready
    );

    modport slave (
        output pcsrc, jaddr, exception, eaddr,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  id_valid, id_instr, id_pc, id_fault,
        output id_ready
    );

endinterface

// File: rtl/if_sync_fifo.sv
// Generic synchronous FIFO with push/pop/flush and an occupancy count.
// Latency: a pushed word is visible on pop_data the cycle after the push.
// Backpressure: none internally; the owner must not push when full unless popping.
// Ports: clk/rst, push+push_data, pop->pop_data (head, combinational), flush, count.
module if_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Explicit wrap so non-power-of-two and single-entry depths still work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; consumers only look at it when count is non-zero.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, issues word reads to imem, buffers words+PC for decode.
// Latency: imem response -> id_valid in 1 cycle; redirect -> first fetch at target 1 cycle
//   later, or the cycle after the last stale response.
// Backpressure: credit-based; a fetch issues only if outstanding+buffered < BUF_DEPTH.
// Ports: clk, rst (async, active-high); bus.master carries pcsrc/jaddr, exception/eaddr,
//   imem_req_{valid,ready,addr}, imem_rsp_{valid,data,err}, id_{valid,ready,instr,pc,fault}.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MAX_OUTST = 2,
    parameter int          BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    if_fetch_unit_if.master bus
);

    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int BW = $clog2(BUF_DEPTH + 1);
    localparam int SW = ((OW > BW) ? OW : BW) + 1;

    if_state_e       state;
    logic [XLEN-1:0] pc;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   outst_next;
    logic [OW-1:0]   drop;
    logic            req_hold;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic            credit;
    logic            req_valid;
    logic            req_fire;
    logic            rsp_keep;
    logic            id_fire;

    logic [OW-1:0]   afifo_count;
    logic [XLEN-1:0] afifo_head;
    logic [BW-1:0]   buf_count;
    ibuf_entry_t     ibuf_in;
    ibuf_entry_t     ibuf_out;

    // Exception outranks a branch redirect in the same cycle.
    assign redirect = bus.pcsrc | bus.exception;
    assign target   = align_word(bus.exception ? bus.eaddr : bus.jaddr);

    // Every in-flight fetch owns a reserved buffer slot, so responses never overflow.
    assign credit = (outstanding < OW'(MAX_OUTST)) &&
                    ((SW'(buf_count) + SW'(outstanding)) < SW'(BUF_DEPTH));

    // A request presented but not yet accepted stays up even if a fault halts issue
    // meanwhile; only a redirect (or reset) may withdraw it.
    assign req_valid = !rst && !redirect && credit &&
                       ((state == IF_STATE_RUN) || req_hold);
    assign req_fire  = req_valid && bus.imem_req_ready;

    // Responses are discarded while stale ones remain or when a redirect lands on them.
    assign rsp_keep = bus.imem_rsp_valid && (drop == '0) && !redirect;
    assign id_fire  = (buf_count != '0) && bus.id_ready;

    always_comb begin
        outst_next = outstanding;
        if (req_fire && !bus.imem_rsp_valid)      outst_next = outstanding + 1'b1;
        else if (!req_fire && bus.imem_rsp_valid) outst_next = outstanding - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IF_STATE_RUN;
            pc          <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            req_hold    <= 1'b0;
        end else begin
            outstanding <= outst_next;
            req_hold    <= req_valid && !bus.imem_req_ready;
            if (redirect) begin
                // Everything still in flight after this cycle is stale.
                pc    <= target;
                drop  <= outst_next;
                state <= (outst_next != '0) ? IF_STATE_DRAIN : IF_STATE_RUN;
            end else begin
                if (req_fire) pc <= pc + 32'd4;
                if (bus.imem_rsp_valid && (drop != '0)) begin
                    drop <= drop - 1'b1;
                    if (drop == OW'(1)) state <= IF_STATE_RUN;
                end else if (rsp_keep && bus.imem_rsp_err) begin
                    state <= IF_STATE_HALT;
                end
            end
        end
    end

    // PCs of in-flight requests, popped in order as responses return (kept or dropped).
    if_sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTST)
    ) u_addr_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .push_data (pc),
        .pop       (bus.imem_rsp_valid),
        .pop_data  (afifo_head),
        .flush     (1'b0),
        .count     (afifo_count)
    );

    assign ibuf_in = '{pc: afifo_head, instr: bus.imem_rsp_data, fault: bus.imem_rsp_err};

    if_sync_fifo #(
        .WIDTH ($bits(ibuf_entry_t)),
        .DEPTH (BUF_DEPTH)
    ) u_instr_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (rsp_keep),
        .push_data (ibuf_in),
        .pop       (id_fire),
        .pop_data  (ibuf_out),
        .flush     (redirect),
        .count     (buf_count)
    );

    // The address FIFO mirrors the outstanding counter exactly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (afifo_count == outstanding);
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc;

    // Decode outputs read as zero whenever nothing is offered.
    assign bus.id_valid = (buf_count != '0);
    assign bus.id_instr = bus.id_valid ? ibuf_out.instr : '0;
    assign bus.id_pc    = bus.id_valid ? ibuf_out.pc    : '0;
    assign bus.id_fault = bus.id_valid && ibuf_out.fault;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
    import if_pkg::*;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          MAX_OUTST = 2;
    localparam int          BUF_DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_fetch_unit_if bus ();

    if_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .MAX_OUTST (MAX_OUTST),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { logic [31:0] addr; bit stale; } memreq_t;
    typedef struct { logic [31:0] pc; bit err; } idexp_t;
    typedef struct {
        bit pcsrc; logic [31:0] jaddr; bit exc; logic [31:0] eaddr; logic [31:0] exp_addr;
    } redir_vec_t;

    // Reference model: in-flight memory requests, expected decode stream, architectural PC.
    memreq_t     mem_q[$];
    idexp_t      exp_q[$];
    logic [31:0] model_pc;
    bit          halted, hold_prev;

    int n_checks = 0, n_fail = 0;
    int acc_cnt = 0, pop_cnt = 0, fault_cnt = 0;
    logic [31:0] last_acc_addr, last_pop_pc, last_fault_pc;

    // Stimulus knobs
    bit          s_pcsrc, s_exc, s_ready, s_idready, rnd, rnd_err;
    logic [31:0] s_jaddr, s_eaddr, fault_addr;
    int          rsp_pct;

    function automatic logic [31:0] idata(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event did not occur within 40 cycles", name);
    endtask

    // One clock: drive at posedge+1, observe and advance the model at negedge.
    task automatic cycle();
        bit          redir, cred, stale, exp_v, rsp;
        memreq_t     m;
        idexp_t      e;
        logic [31:0] tgt;
        @(posedge clk);
        #1;
        if (rnd) begin
            s_ready   = ($urandom_range(0, 3) != 0);
            s_idready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) < 3) begin
                s_pcsrc = $urandom_range(0, 1);
                s_exc   = !s_pcsrc || ($urandom_range(0, 3) == 0);
                s_jaddr = $urandom;
                s_eaddr = $urandom;
            end
        end
        rsp = (mem_q.size() > 0) && ($urandom_range(0, 99) < rsp_pct);
        bus.pcsrc          = s_pcsrc;
        bus.jaddr          = s_jaddr;
        bus.exception      = s_exc;
        bus.eaddr          = s_eaddr;
        bus.imem_req_ready = s_ready;
        bus.id_ready       = s_idready;
        bus.imem_rsp_valid = rsp;
        if (rsp) begin
            m = mem_q[0];
            bus.imem_rsp_data = idata(m.addr);
            bus.imem_rsp_err  = (m.addr == fault_addr) || (rnd_err && $urandom_range(0, 15) == 0);
        end else begin
            bus.imem_rsp_data = $urandom;
            bus.imem_rsp_err  = 1'b0;
        end
        @(negedge clk);

        redir = s_pcsrc || s_exc;
        tgt   = s_exc ? s_eaddr : s_jaddr;
        tgt[1:0] = 2'b00;
        cred  = (mem_q.size() < MAX_OUTST) && (mem_q.size() + exp_q.size() < BUF_DEPTH);
        stale = 1'b0;
        for (int i = 0; i < mem_q.size(); i++) if (mem_q[i].stale) stale = 1'b1;
        exp_v = !redir && cred && ((!halted && !stale) || hold_prev);
        chk("req_valid", bus.imem_req_valid, exp_v);
        if (bus.imem_req_valid) chk("req_addr", bus.imem_req_addr, model_pc);

        chk("id_valid", bus.id_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            e = exp_q[0];
            chk("id_pc", bus.id_pc, e.pc);
            chk("id_instr", bus.id_instr, idata(e.pc));
            chk("id_fault", bus.id_fault, e.err);
            if (s_idready) begin
                void'(exp_q.pop_front());
                pop_cnt++;
                last_pop_pc = e.pc;
                if (e.err) begin
                    fault_cnt++;
                    last_fault_pc = e.pc;
                end
            end
        end

        if (rsp) begin
            m = mem_q.pop_front();
            if (!redir && !m.stale) begin
                exp_q.push_back('{m.addr, bus.imem_rsp_err});
                if (bus.imem_rsp_err) halted = 1'b1;
            end
        end

        if (bus.imem_req_valid && s_ready) begin
            mem_q.push_back('{model_pc, 1'b0});
            last_acc_addr = bus.imem_req_addr;
            model_pc = model_pc + 32'd4;
            acc_cnt++;
        end

        if (redir) begin
            model_pc = tgt;
            exp_q.delete();
            for (int i = 0; i < mem_q.size(); i++) mem_q[i].stale = 1'b1;
            halted = 1'b0;
        end
        hold_prev = bus.imem_req_valid && !s_ready;
        s_pcsrc = 1'b0;
        s_exc   = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        s_pcsrc = 1'b0; s_exc = 1'b0;
        bus.pcsrc = 1'b0; bus.exception = 1'b0; bus.jaddr = '0; bus.eaddr = '0;
        bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = '0; bus.imem_rsp_err = 1'b0; bus.id_ready = 1'b0;
        #1;
        chk("rst_req_valid", bus.imem_req_valid, 0);
        chk("rst_id_valid", bus.id_valid, 0);
        chk("rst_id_instr", bus.id_instr, 0);
        chk("rst_id_pc", bus.id_pc, 0);
        chk("rst_id_fault", bus.id_fault, 0);
        repeat (cycles) @(negedge clk);
        chk("rst_hold_req_valid", bus.imem_req_valid, 0);
        mem_q.delete();
        exp_q.delete();
        model_pc  = RESET_PC;
        halted    = 1'b0;
        hold_prev = 1'b0;
        rst = 1'b0;
    endtask

    task automatic wait_accept(input string name, input logic [31:0] exp_addr);
        int start = acc_cnt;
        for (int i = 0; i < 40 && acc_cnt == start; i++) cycle();
        if (acc_cnt == start) timeout(name);
        else chk(name, last_acc_addr, exp_addr);
    endtask

    task automatic wait_pop(input string name, input logic [31:0] exp_pc);
        int start = pop_cnt;
        for (int i = 0; i < 40 && pop_cnt == start; i++) cycle();
        if (pop_cnt == start) timeout(name);
        else chk(name, last_pop_pc, exp_pc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        redir_vec_t vecs[6];
        int p0, a0;
        vecs[0] = '{1'b1, 32'h0000_0100, 1'b0, 32'h0000_0000, 32'h0000_0100};
        vecs[1] = '{1'b1, 32'h0000_0200, 1'b1, 32'h0000_0080, 32'h0000_0080};
        vecs[2] = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_0043, 32'h0000_0040};
        vecs[3] = '{1'b1, 32'h0000_0007, 1'b0, 32'h0000_1234, 32'h0000_0004};
        vecs[4] = '{1'b0, 32'h0000_0999, 1'b1, 32'h0000_0000, 32'h0000_0000};
        vecs[5] = '{1'b1, 32'h0001_2346, 1'b1, 32'h0000_0FF0, 32'h0000_0FF0};

        rnd = 1'b0; rnd_err = 1'b0; fault_addr = 32'hFFFF_FFFF;
        s_ready = 1'b1; s_idready = 1'b1; rsp_pct = 100;
        s_jaddr = '0; s_eaddr = '0;
        do_reset(3);

        // Straight-line fetch from reset with a 1-cycle memory
        wait_accept("t1_first_fetch", RESET_PC);
        wait_pop("t1_first_id_pc", RESET_PC);
        p0 = pop_cnt;
        repeat (30) cycle();
        chk("t1_throughput", (pop_cnt - p0) >= 12, 1);

        // Decode stalled: credits cap fetches, nothing lost on resume
        s_idready = 1'b0;
        repeat (10) cycle();
        chk("t2_buf_full", exp_q.size(), BUF_DEPTH);
        chk("t2_no_req", bus.imem_req_valid, 0);
        s_idready = 1'b1;
        p0 = pop_cnt;
        repeat (10) cycle();
        chk("t2_resume", (pop_cnt - p0) >= 4, 1);

        // Branch with two requests in flight: both responses dropped
        s_ready = 1'b0;
        repeat (5) cycle();
        s_ready = 1'b1; rsp_pct = 0;
        repeat (3) cycle();
        chk("t3_outstanding", mem_q.size(), 2);
        s_pcsrc = 1'b1; s_jaddr = 32'h0000_0100;
        cycle();
        rsp_pct = 100;
        wait_accept("t3_first_fetch", 32'h0000_0100);
        wait_pop("t3_first_id_pc", 32'h0000_0100);

        // Redirect vectors: priority and target alignment
        rsp_pct = 50;
        for (int i = 0; i < 6; i++) begin
            repeat (3) cycle();
            s_pcsrc = vecs[i].pcsrc; s_jaddr = vecs[i].jaddr;
            s_exc   = vecs[i].exc;   s_eaddr = vecs[i].eaddr;
            cycle();
            wait_accept($sformatf("redir_vec%0d", i), vecs[i].exp_addr);
        end

        // Fetch fault halts issue until an exception redirect
        rsp_pct = 100;
        fault_addr = 32'h0000_0008;
        s_pcsrc = 1'b1; s_jaddr = 32'h0000_0000;
        cycle();
        p0 = fault_cnt;
        for (int i = 0; i < 40 && fault_cnt == p0; i++) cycle();
        if (fault_cnt == p0) timeout("t5_fault_seen");
        else chk("t5_fault_pc", last_fault_pc, 32'h0000_0008);
        a0 = acc_cnt;
        repeat (10) cycle();
        chk("t5_halted", acc_cnt, a0);
        fault_addr = 32'hFFFF_FFFF;
        s_exc = 1'b1; s_eaddr = 32'h0000_0040;
        cycle();
        wait_accept("t5_resume", 32'h0000_0040);

        // Randomised traffic against the model
        rnd = 1'b1; rnd_err = 1'b1; rsp_pct = 60;
        a0 = acc_cnt;
        repeat (2000) cycle();
        rnd = 1'b0; rnd_err = 1'b0;
        s_ready = 1'b1; s_idready = 1'b1;
        chk("rnd_activity", (acc_cnt - a0) > 200, 1);

        // Address wrap, then reset in the middle of a burst
        rsp_pct = 100;
        s_pcsrc = 1'b1; s_jaddr = 32'hFFFF_FFFE;
        cycle();
        wait_accept("t6_top_word", 32'hFFFF_FFFC);
        wait_accept("t6_wrap", 32'h0000_0000);
        rsp_pct = 50;
        repeat (5) cycle();
        do_reset(2);
        rsp_pct = 100;
        wait_accept("t6_restart", RESET_PC);
        wait_pop("t6_restart_id_pc", RESET_PC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
